pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline control for the 5-stage MIPS core.
- Drives the freeze and flush inputs of the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB stage registers.
- Combines three conditions: load-use/RAW hazard detection, branch-taken flush, and a multi-cycle data-memory wait FSM.
- Also counts stall cycles for performance monitoring.

Parameters:
MEM_LAT, 6, data-memory access latency in cycles (legal 1..16); MEM_LAT=1 means no memory freeze.
CNT_W, 4, width of the memory wait down-counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
forward_en  in  1  forwarding unit enabled
src1_id  in  5  rs of the instruction in ID
src2_id  in  5  rt of the instruction in ID
two_src_id  in  1  ID instruction reads src2 (R-type, store, branch)
exe_dest  in  5  Dest leaving the ID/EX register
exe_wb_en  in  1  WB_EN leaving the ID/EX register
exe_mem_r_en  in  1  MEM_R_EN leaving the ID/EX register
mem_dest  in  5  Dest in the EXE/MEM register
mem_wb_en  in  1  WB_EN in the EXE/MEM register
mem_r_en  in  1  load in the MEM stage
mem_w_en  in  1  store in the MEM stage
br_taken  in  1  branch resolved taken in EXE
pc_freeze  out  1  hold PC
if_id_freeze  out  1  hold the IF/ID register
if_id_flush  out  1  clear the IF/ID register
id_ex_freeze  out  1  hold the ID/EX register
id_ex_flush  out  1  insert a bubble into ID/EX
mem_freeze  out  1  hold the EXE/MEM and MEM/WB registers
mem_busy  out  1  memory FSM is not IDLE
stall_count  out  32  number of cycles with pc_freeze=1

Behaviour:
- All outputs except stall_count are combinational from the registered FSM state and the current inputs.
- While rst=1, every output is forced to 0.
- On the rst edge: state<=IDLE, cnt<=0, stall_count<=0.
- match1 = (exe_dest==src1_id); match2 = two_src_id & (exe_dest==src2_id); the same terms apply with mem_dest.
- The destination register 0 never causes a hazard.
- exe_hz = exe_wb_en & exe_dest!=0 & (match1|match2) & (!forward_en | exe_mem_r_en).
- mem_hz = !forward_en & mem_wb_en & mem_dest!=0 & (match1|match2).
- hazard = exe_hz | mem_hz.
- Memory FSM, states IDLE and ACCESS:
  - IDLE with req=(mem_r_en|mem_w_en) and MEM_LAT>=2: freeze=1, cnt<=MEM_LAT-2, go to ACCESS.
  - IDLE with MEM_LAT=1: freeze=0 and the FSM stays in IDLE.
  - ACCESS with cnt!=0: freeze=1, cnt<=cnt-1.
  - ACCESS with cnt==0: freeze=0 (the release cycle, in which the pipeline advances), go to IDLE. req is not sampled in this cycle.
  - Net effect: an access starting at cycle t holds mem_freeze high for cycles t..t+MEM_LAT-2 and releases it at t+MEM_LAT-1.
  - Back-to-back memory instructions therefore restart the FSM in the cycle after release.
- mem_freeze = FSM freeze. mem_busy = (state!=IDLE).
- Output equations:
  - pc_freeze = mem_freeze | (hazard & !br_taken).
  - if_id_freeze = pc_freeze.
  - if_id_flush = br_taken & !mem_freeze.
  - id_ex_freeze = mem_freeze.
  - id_ex_flush = (br_taken | hazard) & !mem_freeze.
- Priority:
  - mem_freeze overrides everything; all flushes are suppressed while it is high.
  - A branch that is pending during a memory wait takes effect in the release cycle.
  - br_taken beats hazard: the PC loads the branch target and the hazarding ID instruction is flushed, not stalled.
- stall_count increments by 1 on every clk edge where pc_freeze=1 and rst=0; it wraps from 0xFFFFFFFF to 0.
- rst asserted in the middle of ACCESS aborts the access: the FSM returns to IDLE and cnt is cleared.

Test Plan:
- Load-use stall: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1_id=5 -> pc_freeze=1, if_id_freeze=1, id_ex_flush=1. Changing exe_dest to 0 -> all three outputs go to 0.
- No forwarding: forward_en=0, mem_wb_en=1, mem_dest=7, src2_id=7 -> two_src_id=1 gives a stall; two_src_id=0 gives no stall.
- Branch vs hazard: br_taken=1 together with a load-use hazard -> pc_freeze=0, if_id_flush=1, id_ex_flush=1.
- Memory latency, MEM_LAT=6: mem_r_en held 1 from cycle 0 -> mem_freeze=1 in cycles 0..4, 0 in cycle 5, 1 again in cycle 6. stall_count=10 after cycle 10.
- Branch during freeze: br_taken=1 in cycle 2 of an access -> if_id_flush=0 in cycles 2..4; if_id_flush=1 and id_ex_flush=1 in cycle 5.
- Reset mid-access: rst=1 in cycle 3 -> outputs 0 that cycle, state IDLE, stall_count=0. With MEM_LAT=1 a store gives mem_freeze=0 always.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the central
// stall/flush controller. The datapath side uses master; the controller uses slave.
interface pipeline_hazard_ctrl_if;
   // Hazard-detection and memory-request inputs
   logic        forward_en;
   logic [4:0]  src1_id;
   logic [4:0]  src2_id;
   logic        two_src_id;
   logic [4:0]  exe_dest;
   logic        exe_wb_en;
   logic        exe_mem_r_en;
   logic [4:0]  mem_dest;
   logic        mem_wb_en;
   logic        mem_r_en;
   logic        mem_w_en;
   logic        br_taken;
   // Stage-register control outputs
   logic        pc_freeze;
   logic        if_id_freeze;
   logic        if_id_flush;
   logic        id_ex_freeze;
   logic        id_ex_flush;
   logic        mem_freeze;
   logic        mem_busy;
   logic [31:0] stall_count;

   modport master (
      output forward_en, src1_id, src2_id, two_src_id, exe_dest, exe_wb_en,
             exe_mem_r_en, mem_dest, mem_wb_en, mem_r_en, mem_w_en, br_taken,
      input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
             mem_freeze, mem_busy, stall_count
   );

   modport slave (
      input  forward_en, src1_id, src2_id, two_src_id, exe_dest, exe_wb_en,
             exe_mem_r_en, mem_dest, mem_wb_en, mem_r_en, mem_w_en, br_taken,
      output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
             mem_freeze, mem_busy, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central freeze/flush control for the 5-stage pipeline: RAW/load-use
// detection, taken-branch flush, a multi-cycle data-memory wait FSM and a
// stall-cycle performance counter.
module pipeline_hazard_ctrl #(
   parameter int MEM_LAT = 6,   // data-memory latency, 1..16 (1 = no wait)
   parameter int CNT_W   = 4    // wait counter width, 2**CNT_W > MEM_LAT
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   localparam logic             LP_USE_WAIT = (MEM_LAT >= 2);
   localparam logic [CNT_W-1:0] LP_CNT_LOAD = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_stall_count;

   logic w_match1_exe, w_match2_exe, w_match1_mem, w_match2_mem;
   logic w_exe_hz, w_mem_hz, w_hazard;
   logic w_req, w_fsm_freeze, w_pc_freeze;

   // Operand matches against the EXE and MEM destinations; $zero never hazards
   always_comb begin
      w_match1_exe = (bus.exe_dest == bus.src1_id);
      w_match2_exe = bus.two_src_id & (bus.exe_dest == bus.src2_id);
      w_match1_mem = (bus.mem_dest == bus.src1_id);
      w_match2_mem = bus.two_src_id & (bus.mem_dest == bus.src2_id);
      // An EXE producer stalls unless it can be forwarded (loads never can)
      w_exe_hz = bus.exe_wb_en & (bus.exe_dest != 5'd0) & (w_match1_exe | w_match2_exe)
               & (~bus.forward_en | bus.exe_mem_r_en);
      // A MEM producer only stalls when forwarding is disabled
      w_mem_hz = ~bus.forward_en & bus.mem_wb_en & (bus.mem_dest != 5'd0)
               & (w_match1_mem | w_match2_mem);
      w_hazard = w_exe_hz | w_mem_hz;
   end

   // Memory wait freeze, decoded from the registered FSM state and the request
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_fsm_freeze = 1'b0;
      w_req        = bus.mem_r_en | bus.mem_w_en;
      case (r_state)
         ST_IDLE:   w_fsm_freeze = w_req & LP_USE_WAIT;
         ST_ACCESS: w_fsm_freeze = (r_cnt != '0);
         default:   w_fsm_freeze = 1'b0;
      endcase
      // Memory wait dominates; a taken branch redirects instead of stalling
      w_pc_freeze = w_fsm_freeze | (w_hazard & ~bus.br_taken);
   end

   // Memory wait FSM: freeze for MEM_LAT-1 cycles, then one release cycle
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req && LP_USE_WAIT) begin
                  r_state <= ST_ACCESS;
                  r_cnt   <= LP_CNT_LOAD;
               end
            end
            ST_ACCESS: begin
               if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
               else             r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Performance counter: one count per cycle with the PC held, wraps naturally
   always_ff @(posedge clk) begin
      if (rst)              r_stall_count <= '0;
      else if (w_pc_freeze) r_stall_count <= r_stall_count + 32'd1;
   end

   // Stage-register controls, all forced low while reset is asserted
   always_comb begin
      bus.pc_freeze    = ~rst & w_pc_freeze;
      bus.if_id_freeze = ~rst & w_pc_freeze;
      bus.if_id_flush  = ~rst & bus.br_taken & ~w_fsm_freeze;
      bus.id_ex_freeze = ~rst & w_fsm_freeze;
      bus.id_ex_flush  = ~rst & (bus.br_taken | w_hazard) & ~w_fsm_freeze;
      bus.mem_freeze   = ~rst & w_fsm_freeze;
      bus.mem_busy     = ~rst & (r_state != ST_IDLE);
      bus.stall_count  = rst ? 32'd0 : r_stall_count;
   end

endmodule
